conv_mac: RTL and testbench

- Pipelined multiply-accumulate engine for the convolution datapath.
- Consumes a stream of signed Q4.4 pixel/weight pairs plus a per-window bias, and accumulates KERNEL_SIZE products per output window.
- Emits one signed 20-bit Q12.8 sum per window: 8 fractional bits, suitable for direct feed to the rounding/saturation stage that reduces it to 8 bits.
- Sits directly upstream of that reduction stage.

---
 rtl/conv_mac.sv | 118 +++++++++++
 tb/tb_conv_mac.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac.sv
// Pipelined signed multiply-accumulate for one convolution window.
// Q4.4 x Q4.4 products are summed onto a Q12.8 bias, giving one result per KERNEL_SIZE beats.
module conv_mac #(
   parameter int DATA_WIDTH  = 8,
   parameter int ACC_WIDTH   = 20,
   parameter int KERNEL_SIZE = 9,
   parameter int CNT_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] pixel,
   input  logic [DATA_WIDTH-1:0] weight,
   input  logic [ACC_WIDTH-1:0]  bias,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_data
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(KERNEL_SIZE - 1);

   logic                         en;
   logic                         accept;
   logic                         beat_first;
   logic                         beat_last;
   logic signed [ACC_WIDTH-1:0]  sum;

   logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
   logic                         s1_valid_q, s1_valid_d;
   logic                         s1_first_q, s1_first_d;
   logic                         s1_last_q, s1_last_d;
   logic signed [PROD_WIDTH-1:0] s1_prod_q, s1_prod_d;
   logic signed [ACC_WIDTH-1:0]  s1_bias_q, s1_bias_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                         out_valid_q, out_valid_d;
   logic signed [ACC_WIDTH-1:0]  out_data_q, out_data_d;

   always_comb begin
      en         = !out_valid_q || out_ready;
      accept     = in_valid && en;
      beat_first = (cnt_q == '0);
      beat_last  = (cnt_q == LAST_CNT);
      // The Q8.8 product already has 8 fractional bits, so plain sign extension aligns it.
      sum = (s1_first_q ? s1_bias_q : acc_q) + ACC_WIDTH'(s1_prod_q);

      cnt_d       = cnt_q;
      s1_valid_d  = s1_valid_q;
      s1_first_d  = s1_first_q;
      s1_last_d   = s1_last_q;
      s1_prod_d   = s1_prod_q;
      s1_bias_d   = s1_bias_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (clear) begin
         cnt_d       = '0;
         s1_valid_d  = 1'b0;
         acc_d       = '0;
         out_valid_d = 1'b0;
      end else if (en) begin
         s1_valid_d = accept;
         if (accept) begin
            cnt_d      = beat_last ? '0 : cnt_q + CNT_WIDTH'(1);
            s1_prod_d  = PROD_WIDTH'($signed(pixel)) * PROD_WIDTH'($signed(weight));
            s1_first_d = beat_first;
            s1_last_d  = beat_last;
            if (beat_first) begin
               s1_bias_d = bias;
            end
         end
         if (s1_valid_q) begin
            acc_d = sum;
         end
         // A completing window reloads the output in the same cycle the old one drains.
         if (s1_valid_q && s1_last_q) begin
            out_data_d  = sum;
            out_valid_d = 1'b1;
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_prod_q   <= '0;
         s1_bias_q   <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s1_prod_q   <= s1_prod_d;
         s1_bias_q   <= s1_bias_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_comb begin
      in_ready  = en;
      out_valid = out_valid_q;
      out_data  = out_data_q;
   end

endmodule

// File: tb/tb_conv_mac.sv
// Self-checking bench for conv_mac: directed windows plus randomized streams against a window-sum model.
module tb_conv_mac;

   typedef logic [7:0]  opnd_arr_t [9];
   typedef logic [19:0] bias_arr_t [9];

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  pixel;
   logic [7:0]  weight;
   logic [19:0] bias;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_data;

   int checks;
   int errors;
   logic [19:0] last_result;

   conv_mac #(
      .DATA_WIDTH (8),
      .ACC_WIDTH  (20),
      .KERNEL_SIZE(9),
      .CNT_WIDTH  (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .pixel    (pixel),
      .weight   (weight),
      .bias     (bias),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   always #5 clk = ~clk;

   // Window result: first-beat bias plus the nine integer products, wrapped to 20 bits.
   function automatic logic [19:0] ref_sum(input logic [19:0] b0, input opnd_arr_t p, input opnd_arr_t w);
      int s;
      s = int'($signed(b0));
      for (int k = 0; k < 9; k++) begin
         s += int'($signed(p[k])) * int'($signed(w[k]));
      end
      return s[19:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_window(input opnd_arr_t p, input opnd_arr_t w, input bias_arr_t b);
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1;
         pixel    = p[k];
         weight   = w[k];
         bias     = b[k];
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic fill_const(output opnd_arr_t p, output opnd_arr_t w, output bias_arr_t b,
                             input logic [7:0] pv, input logic [7:0] wv, input logic [19:0] bv);
      for (int k = 0; k < 9; k++) begin
         p[k] = pv;
         w[k] = wv;
         b[k] = bv;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 20'h0) begin
         $display("FAIL reset_out: got valid=%b data=%h, expected valid=0 data=00000", out_valid, out_data);
         errors++;
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL reset_ready: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
         errors++;
      end
   endtask

   task automatic test_fixed_window(input string name, input logic [7:0] pv, input logic [7:0] wv,
                                    input logic [19:0] b_first, input logic [19:0] b_rest,
                                    input logic [19:0] expected);
      opnd_arr_t p, w;
      bias_arr_t b;
      fill_const(p, w, b, pv, wv, b_rest);
      b[0] = b_first;
      drive_window(p, w, b);
      checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL %s_early: out_valid=%b one cycle after last beat, expected 0", name, out_valid);
         errors++;
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expected) begin
         $display("FAIL %s: got valid=%b data=%h, expected valid=1 data=%h", name, out_valid, out_data, expected);
         errors++;
      end
      checks++;
      if (ref_sum(b[0], p, w) !== expected) begin
         $display("FAIL %s_model: model gives %h, expected %h", name, ref_sum(b[0], p, w), expected);
         errors++;
      end
      last_result = expected;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL %s_drain: out_valid=%b after acceptance, expected 0", name, out_valid);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      opnd_arr_t p [3];
      opnd_arr_t w [3];
      bias_arr_t b [3];
      logic [19:0] exp_sum [3];
      logic exp_valid;
      int widx;
      for (int n = 0; n < 3; n++) begin
         for (int k = 0; k < 9; k++) begin
            p[n][k] = 8'($urandom);
            w[n][k] = 8'($urandom);
            b[n][k] = 20'($urandom);
         end
         exp_sum[n] = ref_sum(b[n][0], p[n], w[n]);
      end
      out_ready = 1'b1;
      for (int s = 1; s <= 28; s++) begin
         if (s <= 27) begin
            in_valid = 1'b1;
            pixel    = p[(s - 1) / 9][(s - 1) % 9];
            weight   = w[(s - 1) / 9][(s - 1) % 9];
            bias     = b[(s - 1) / 9][(s - 1) % 9];
            checks++;
            if (in_ready !== 1'b1) begin
               $display("FAIL b2b_in_ready: beat %0d in_ready=%b, expected 1", s, in_ready);
               errors++;
            end
         end else begin
            in_valid = 1'b0;
         end
         step();
         exp_valid = (s >= 10) && ((s - 10) % 9 == 0);
         widx = (s - 10) / 9;
         checks++;
         if (out_valid !== exp_valid) begin
            $display("FAIL b2b_valid: step %0d out_valid=%b, expected %b", s, out_valid, exp_valid);
            errors++;
         end else if (exp_valid) begin
            checks++;
            if (out_data !== exp_sum[widx]) begin
               $display("FAIL b2b_data: window %0d got %h, expected %h", widx, out_data, exp_sum[widx]);
               errors++;
            end
         end
      end
      in_valid = 1'b0;
      last_result = exp_sum[2];
      step();
   endtask

   task automatic test_backpressure();
      opnd_arr_t pa, wa, pb, wb;
      bias_arr_t ba, bb;
      logic [19:0] exp_a, exp_b;
      for (int k = 0; k < 9; k++) begin
         pa[k] = 8'($urandom);
         wa[k] = 8'($urandom);
         ba[k] = 20'($urandom);
         pb[k] = 8'($urandom);
         wb[k] = 8'($urandom);
         bb[k] = 20'($urandom);
      end
      exp_a = ref_sum(ba[0], pa, wa);
      exp_b = ref_sum(bb[0], pb, wb);
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1;
         pixel    = pa[k];
         weight   = wa[k];
         bias     = ba[k];
         step();
      end
      pixel  = pb[0];
      weight = wb[0];
      bias   = bb[0];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_a) begin
         $display("FAIL bp_first: got valid=%b data=%h, expected valid=1 data=%h", out_valid, out_data, exp_a);
         errors++;
      end
      out_ready = 1'b0;
      pixel     = pb[1];
      weight    = wb[1];
      bias      = bb[1];
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_a) begin
            $display("FAIL bp_stall: cycle %0d in_ready=%b valid=%b data=%h, expected 0/1/%h",
                     c, in_ready, out_valid, out_data, exp_a);
            errors++;
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL bp_release: in_ready=%b, expected 1", in_ready);
         errors++;
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL bp_drain: out_valid=%b, expected 0", out_valid);
         errors++;
      end
      for (int k = 2; k < 9; k++) begin
         pixel  = pb[k];
         weight = wb[k];
         bias   = bb[k];
         step();
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_b) begin
         $display("FAIL bp_second: got valid=%b data=%h, expected valid=1 data=%h", out_valid, out_data, exp_b);
         errors++;
      end
      last_result = exp_b;
      step();
   endtask

   task automatic test_clear_mid_window();
      opnd_arr_t p, w;
      bias_arr_t b;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         pixel    = 8'($urandom);
         weight   = 8'($urandom);
         bias     = 20'($urandom);
         step();
      end
      clear  = 1'b1;
      pixel  = 8'h11;
      weight = 8'h22;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== last_result) begin
         $display("FAIL clear_state: got valid=%b data=%h, expected valid=0 data=%h", out_valid, out_data, last_result);
         errors++;
      end
      repeat (3) step();
      checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL clear_no_output: out_valid=%b, expected 0", out_valid);
         errors++;
      end
      fill_const(p, w, b, 8'h10, 8'h10, 20'h0);
      drive_window(p, w, b);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 20'h00900) begin
         $display("FAIL clear_next_window: got valid=%b data=%h, expected valid=1 data=00900", out_valid, out_data);
         errors++;
      end
      last_result = 20'h00900;
      step();
   endtask

   task automatic test_reset_mid_window();
      opnd_arr_t p, w;
      bias_arr_t b;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         pixel    = 8'($urandom);
         weight   = 8'($urandom);
         bias     = 20'($urandom);
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 20'h0) begin
         $display("FAIL async_reset: got valid=%b data=%h, expected valid=0 data=00000", out_valid, out_data);
         errors++;
      end
      step();
      rst_n = 1'b1;
      step();
      fill_const(p, w, b, 8'h10, 8'h10, 20'h0);
      drive_window(p, w, b);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 20'h00900) begin
         $display("FAIL reset_next_window: got valid=%b data=%h, expected valid=1 data=00900", out_valid, out_data);
         errors++;
      end
      step();
   endtask

   initial begin
      clk         = 1'b0;
      rst_n       = 1'b0;
      clear       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      pixel       = '0;
      weight      = '0;
      bias        = '0;
      checks      = 0;
      errors      = 0;
      last_result = '0;

      test_reset();
      test_fixed_window("unity", 8'h10, 8'h10, 20'h00000, 20'h00000, 20'h00900);
      test_fixed_window("neg_extreme", 8'h80, 8'h7F, 20'h00000, 20'h00000, 20'hDC480);
      test_fixed_window("bias_capture", 8'h10, 8'h08, 20'h00080, 20'hFFFFF, 20'h00500);
      test_back_to_back();
      test_backpressure();
      test_clear_mid_window();
      test_reset_mid_window();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
